// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage memory access path.
// Holds RISC-V load/store size encodings and the access FSM state type.
package riscv_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper: byte enables, store replication, legality/alignment
// from the launching fields; sign/zero extension of the returned word.
module mem_align
  import riscv_pkg::*;
(
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] sdata_i,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        legal_o,
  output logic        aligned_o,
  output logic [31:0] ldata_o
);

  logic ld_ok;
  logic st_ok;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    ld_ok     = 1'b0;
    st_ok     = 1'b0;
    aligned_o = 1'b0;
    be_o      = 4'b0000;
    wdata_o   = sdata_i;
    case (size_i)
      MEM_B, MEM_BU: begin
        ld_ok     = 1'b1;
        st_ok     = (size_i == MEM_B);
        aligned_o = 1'b1;
        be_o      = 4'b0001 << lane_i;
        wdata_o   = {4{sdata_i[7:0]}};
      end
      MEM_H, MEM_HU: begin
        ld_ok     = 1'b1;
        st_ok     = (size_i == MEM_H);
        aligned_o = ~lane_i[0];
        be_o      = 4'b0011 << {lane_i[1], 1'b0};
        wdata_o   = {2{sdata_i[15:0]}};
      end
      MEM_W: begin
        ld_ok     = 1'b1;
        st_ok     = 1'b1;
        aligned_o = (lane_i == 2'b00);
        be_o      = 4'b1111;
      end
      default: ;
    endcase
    legal_o = (rd_i & ~wr_i & ld_ok)
            | (wr_i & ~rd_i & st_ok);
  end

  always_comb begin
    byte_sel = rdata_i[8*ld_lane_i +: 8];
    half_sel = ld_lane_i[1] ? rdata_i[31:16]
                            : rdata_i[15:0];
    case (ld_size_i)
      MEM_B:   ldata_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  ldata_o = {24'd0, byte_sel};
      MEM_H:   ldata_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  ldata_o = {16'd0, half_sel};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Execute-stage load/store engine: one req/ack transaction per access,
// stalls the pipeline via mem_busy, returns extended load data or errors.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_e,
  input  logic        mem_write_e,
  input  logic [2:0]  mem_size_e,
  input  logic [31:0] addr_e,
  input  logic [31:0] store_data_e,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_busy,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  mau_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       size_q;
  logic [1:0]       lane_q;

  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] ldata_w;
  logic        legal;
  logic        aligned;
  logic        idle;
  logic        start;

  mem_align u_align (
    .rd_i      (mem_read_e),
    .wr_i      (mem_write_e),
    .size_i    (mem_size_e),
    .lane_i    (addr_e[1:0]),
    .sdata_i   (store_data_e),
    .ld_size_i (size_q),
    .ld_lane_i (lane_q),
    .rdata_i   (dmem_rdata),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .legal_o   (legal),
    .aligned_o (aligned),
    .ldata_o   (ldata_w)
  );

  // legal already implies exactly one of read/write is set
  always_comb begin
    idle       = (state_q == IDLE);
    start      = idle & legal & aligned;
    misaligned = idle & (mem_read_e | mem_write_e)
               & ~(legal & aligned);
    mem_busy   = start | (state_q == REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= 3'b000;
      lane_q     <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'd0;
      load_valid <= 1'b0;
      load_data  <= 32'd0;
      bus_error  <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      bus_error  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= REQ;
            cnt_q      <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_e;
            dmem_addr  <= {addr_e[31:2], 2'b00};
            dmem_be    <= be_w;
            dmem_wdata <= wdata_w;
            size_q     <= mem_size_e;
            lane_q     <= addr_e[1:0];
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state_q    <= DONE;
            dmem_req   <= 1'b0;
            load_valid <= ~dmem_we;
            if (!dmem_we) load_data <= ldata_w;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            state_q   <= DONE;
            dmem_req  <= 1'b0;
            bus_error <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, errors, watchdog,
// reset during an access; expected values are hand-computed constants.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_e = 1'b0;
  logic        mem_write_e = 1'b0;
  logic [2:0]  mem_size_e = 3'b000;
  logic [31:0] addr_e = 32'd0;
  logic [31:0] store_data_e = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        mem_busy;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .mem_read_e   (mem_read_e),
    .mem_write_e  (mem_write_e),
    .mem_size_e   (mem_size_e),
    .addr_e       (addr_e),
    .store_data_e (store_data_e),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .mem_busy     (mem_busy),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .bus_error    (bus_error)
  );

  localparam logic [2:0]  LX_SZ [5] =
    '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
  localparam logic [31:0] LX_AD [5] =
    '{32'h0000_0103, 32'h0000_0103, 32'h0000_0102,
      32'h0000_0200, 32'h0000_0301};
  localparam logic [31:0] LX_RD [5] =
    '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
      32'h1234_8001, 32'h0000_7F00};
  localparam logic [3:0]  LX_BE [5] =
    '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
  localparam logic [31:0] LX_EX [5] =
    '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
      32'hFFFF_8001, 32'h0000_007F};
  localparam logic [31:0] LX_WA [5] =
    '{32'h0000_0100, 32'h0000_0100, 32'h0000_0100,
      32'h0000_0200, 32'h0000_0300};

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] sz,
                       input logic [31:0] ad,
                       input logic [31:0] sd);
    mem_read_e   = rd;
    mem_write_e  = wr;
    mem_size_e   = sz;
    addr_e       = ad;
    store_data_e = sd;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
        dmem_be !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl got req=%b we=%b be=%b exp 0 0 0000",
               dmem_req, dmem_we, dmem_be);
    end
    checks++;
    if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 ||
        load_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h ld=%h exp zeros",
               dmem_addr, dmem_wdata, load_data);
    end
    checks++;
    if (load_valid !== 1'b0 || bus_error !== 1'b0 ||
        mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got lv=%b be=%b busy=%b exp 0",
               load_valid, bus_error, mem_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'd0);
    #1;
    checks++;
    if (mem_busy !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_idle got busy=%b req=%b exp 1 0",
               mem_busy, dmem_req);
    end
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 ||
        dmem_addr !== 32'h1000_0004 || dmem_be !== 4'b1111 ||
        mem_busy !== 1'b1) begin
      errors++;
      $display("FAIL lw_req got req=%b we=%b a=%h be=%b busy=%b exp 1 0 10000004 1111 1",
               dmem_req, dmem_we, dmem_addr, dmem_be, mem_busy);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if (load_valid !== 1'b1 || load_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_done got lv=%b ld=%h exp 1 deadbeef",
               load_valid, load_data);
    end
    checks++;
    if (mem_busy !== 1'b0 || dmem_req !== 1'b0 ||
        bus_error !== 1'b0) begin
      errors++;
      $display("FAIL lw_done_ctl got busy=%b req=%b berr=%b exp 0 0 0",
               mem_busy, dmem_req, bus_error);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checks++;
    if (load_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_after got lv=%b req=%b exp 0 0",
               load_valid, dmem_req);
    end
  endtask

  task automatic test_load_ext();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, LX_SZ[i], LX_AD[i], 32'd0);
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_be !== LX_BE[i] ||
          dmem_addr !== LX_WA[i]) begin
        errors++;
        $display("FAIL ld_ext_req[%0d] got req=%b be=%b a=%h exp 1 %b %h",
                 i, dmem_req, dmem_be, dmem_addr, LX_BE[i], LX_WA[i]);
      end
      dmem_ack = 1'b1;
      dmem_rdata = LX_RD[i];
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
      checks++;
      if (load_valid !== 1'b1 || load_data !== LX_EX[i]) begin
        errors++;
        $display("FAIL ld_ext[%0d] got lv=%b ld=%h exp 1 %h",
                 i, load_valid, load_data, LX_EX[i]);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    end
  endtask

  task automatic test_store();
    logic [2:0]  sz [2] = '{3'b001, 3'b000};
    logic [31:0] ad [2] = '{32'h2000_0002, 32'h0000_0301};
    logic [31:0] sd [2] = '{32'h1234_ABCD, 32'hA5A5_0055};
    logic [3:0]  eb [2] = '{4'b1100, 4'b0010};
    logic [31:0] ew [2] = '{32'hABCD_ABCD, 32'h5555_5555};
    logic [31:0] ea [2] = '{32'h2000_0000, 32'h0000_0300};
    int          dl [2] = '{3, 0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, sz[i], ad[i], sd[i]);
      for (int c = 0; c <= dl[i]; c++) begin
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 ||
            dmem_be !== eb[i] || dmem_wdata !== ew[i] ||
            dmem_addr !== ea[i] || mem_busy !== 1'b1) begin
          errors++;
          $display("FAIL st_req[%0d.%0d] got req=%b we=%b be=%b wd=%h a=%h busy=%b exp 1 1 %b %h %h 1",
                   i, c, dmem_req, dmem_we, dmem_be, dmem_wdata,
                   dmem_addr, mem_busy, eb[i], ew[i], ea[i]);
        end
        if (c == dl[i]) dmem_ack = 1'b1;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      checks++;
      if (load_valid !== 1'b0 || bus_error !== 1'b0 ||
          dmem_req !== 1'b0 || mem_busy !== 1'b0) begin
        errors++;
        $display("FAIL st_done[%0d] got lv=%b berr=%b req=%b busy=%b exp 0 0 0 0",
                 i, load_valid, bus_error, dmem_req, mem_busy);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    end
  endtask

  task automatic test_misaligned();
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        wr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  sz [4] = '{3'b010, 3'b001, 3'b000, 3'b100};
    logic [31:0] ad [4] = '{32'h0000_0401, 32'h0000_0403,
                            32'h0000_0400, 32'h0000_0400};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(rd[i], wr[i], sz[i], ad[i], 32'h1111_2222);
      #1;
      checks++;
      if (misaligned !== 1'b1 || mem_busy !== 1'b0 ||
          dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL mis[%0d] got mis=%b busy=%b req=%b exp 1 0 0",
                 i, misaligned, mem_busy, dmem_req);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      #1;
      checks++;
      if (misaligned !== 1'b0 || dmem_req !== 1'b0 ||
          mem_busy !== 1'b0) begin
        errors++;
        $display("FAIL mis_after[%0d] got mis=%b req=%b busy=%b exp 0 0 0",
                 i, misaligned, dmem_req, mem_busy);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ended = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      if (dmem_req === 1'b1) n++;
      else ended = 1'b1;
    end
    checks++;
    if (!ended || n != 16) begin
      errors++;
      $display("FAIL to_len got req_cycles=%0d ended=%0d exp 16 1",
               n, ended);
    end
    checks++;
    if (bus_error !== 1'b1 || load_valid !== 1'b0 ||
        mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_done got berr=%b lv=%b busy=%b exp 1 0 0",
               bus_error, load_valid, mem_busy);
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus_error !== 1'b0 || dmem_req !== 1'b0 ||
        mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_idle got berr=%b req=%b busy=%b exp 0 0 0",
               bus_error, dmem_req, mem_busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rm_req1 got req=%b exp 1", dmem_req);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_async got req=%b busy=%b exp 0 0",
               dmem_req, mem_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if (load_valid !== 1'b0 || dmem_req !== 1'b0 ||
        load_data !== 32'd0) begin
      errors++;
      $display("FAIL rm_late_ack got lv=%b req=%b ld=%h exp 0 0 0",
               load_valid, dmem_req, load_data);
    end
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'd0);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0044) begin
      errors++;
      $display("FAIL rm_new_req got req=%b a=%h exp 1 00000044",
               dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if (load_valid !== 1'b1 || load_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rm_new_done got lv=%b ld=%h exp 1 cafef00d",
               load_valid, load_data);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
